// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - IFU/LSU arbiter onto a single memory port, one transaction in flight
module mem_bus_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [31:0] ifu_addr,
   output logic        ifu_rsp_valid,
   output logic [31:0] ifu_rdata,
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic [31:0] lsu_addr,
   input  logic        lsu_wen,
   input  logic [31:0] lsu_wdata,
   input  logic [3:0]  lsu_wmask,
   output logic        lsu_rsp_valid,
   output logic [31:0] lsu_rdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rdata,
   output logic        owner,
   output logic        busy
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] starve_cnt;
   logic [31:0]      lat_addr, lat_wdata;
   logic             lat_wen, lat_owner;
   logic [3:0]       lat_wmask;
   logic             grant_ifu, grant_lsu;

   // rst_n is active-high; no grant may be issued while it is asserted
   always_comb begin
      grant_lsu = 1'b0;
      grant_ifu = 1'b0;
      if (state == S_IDLE && !rst_n) begin
         if (lsu_req_valid && !(ifu_req_valid && starve_cnt == LIMIT))
            grant_lsu = 1'b1;
         else if (ifu_req_valid)
            grant_ifu = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state      <= S_IDLE;
         starve_cnt <= '0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_wen    <= 1'b0;
         lat_wmask  <= '0;
         lat_owner  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant_lsu) begin
            lat_addr  <= lsu_addr;
            lat_wen   <= lsu_wen;
            lat_wdata <= lsu_wen ? lsu_wdata : 32'h0;
            lat_wmask <= lsu_wen ? lsu_wmask : 4'h0;
            lat_owner <= 1'b1;
            if (ifu_req_valid && starve_cnt != LIMIT)
               starve_cnt <= starve_cnt + 1'b1;
         end else if (grant_ifu) begin
            lat_addr   <= ifu_addr;
            lat_wen    <= 1'b0;
            lat_wdata  <= 32'h0;
            lat_wmask  <= 4'h0;
            lat_owner  <= 1'b0;
            starve_cnt <= '0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant_ifu || grant_lsu) state_nxt = S_REQ;
         S_REQ:   if (mem_req_ready) state_nxt = S_WAIT;
         S_WAIT:  if (mem_rsp_valid) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Responses are only honoured in WAIT; strays elsewhere are dropped
   always_comb begin
      ifu_req_ready = grant_ifu;
      lsu_req_ready = grant_lsu;
      mem_req_valid = (state == S_REQ);
      mem_addr      = lat_addr;
      mem_wen       = lat_wen;
      mem_wdata     = lat_wdata;
      mem_wmask     = lat_wmask;
      owner         = lat_owner;
      busy          = (state != S_IDLE);
      ifu_rsp_valid = 1'b0;
      ifu_rdata     = 32'h0;
      lsu_rsp_valid = 1'b0;
      lsu_rdata     = 32'h0;
      if (state == S_WAIT && mem_rsp_valid) begin
         if (lat_owner) begin
            lsu_rsp_valid = 1'b1;
            lsu_rdata     = mem_rdata;
         end else begin
            ifu_rsp_valid = 1'b1;
            ifu_rdata     = mem_rdata;
         end
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
   logic        clk;
   logic        rst_n;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic        owner, busy;

   typedef struct {
      logic        own;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   bit   glog[$];
   int   checks = 0;
   int   errors = 0;
   int   lsu_rsp_cnt = 0;
   int   stall_cfg = 0;
   int   rsp_delay = 0;
   int   spur_cnt = 0;

   mem_bus_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
      .owner(owner), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h0010_0073 : (a ^ 32'hA5A5_5A5A);
   endfunction

   function automatic exp_t mk(input logic own, input logic [31:0] a);
      exp_t e;
      e.own  = own;
      e.data = mem_val(a);
      return e;
   endfunction

   // Memory model: accepts after stall_cfg REQ cycles, answers rsp_delay cycles after the handshake
   initial begin
      int stall_ctr = 0;
      int rsp_cd = 0;
      int spur_seen = 0;
      logic [31:0] rsp_data = 32'h0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rdata     = 32'h0;
      forever begin
         @(negedge clk);
         if (mem_req_valid && !rst_n) begin
            if (stall_ctr < stall_cfg) begin
               stall_ctr++;
            end else begin
               stall_ctr     = 0;
               mem_req_ready = 1'b1;
               rsp_cd        = rsp_delay + 1;
               rsp_data      = mem_val(mem_addr);
               if (!mem_wen) check_eq("read_wmask_zero", {28'h0, mem_wmask}, 32'h0);
            end
         end
         @(posedge clk);
         #1;
         mem_req_ready = 1'b0;
         mem_rsp_valid = 1'b0;
         mem_rdata     = 32'h0;
         if (rsp_cd > 0) begin
            rsp_cd--;
            if (rsp_cd == 0) begin
               mem_rsp_valid = 1'b1;
               mem_rdata     = rsp_data;
            end
         end else if (spur_cnt != spur_seen) begin
            spur_seen++;
            mem_rsp_valid = 1'b1;
            mem_rdata     = 32'hBAD0_BAD0;
         end
      end
   end

   // Grant log and response scoreboard
   always @(negedge clk) begin
      if (ifu_req_ready) glog.push_back(1'b0);
      if (lsu_req_ready) glog.push_back(1'b1);
      if (ifu_req_ready && lsu_req_ready) check_eq("double_grant", 32'd1, 32'd0);
      if (lsu_rsp_valid) lsu_rsp_cnt++;
      if (ifu_rsp_valid || lsu_rsp_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_rsp", {30'h0, ifu_rsp_valid, lsu_rsp_valid}, 32'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("rsp_owner", {31'h0, lsu_rsp_valid}, {31'h0, e.own});
            check_eq("rsp_single", {31'h0, ifu_rsp_valid & lsu_rsp_valid}, 32'h0);
            check_eq("rsp_data", lsu_rsp_valid ? lsu_rdata : ifu_rdata, e.data);
            check_eq("nonowner_rdata", lsu_rsp_valid ? ifu_rdata : lsu_rdata, 32'h0);
         end
      end
   end

   task automatic issue_ifu(input logic [31:0] a);
      int n = 0;
      ifu_req_valid = 1'b1;
      ifu_addr      = a;
      @(negedge clk);
      while (!ifu_req_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!ifu_req_ready) check_eq("ifu_grant_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      ifu_req_valid = 1'b0;
   endtask

   task automatic issue_lsu(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
      int n = 0;
      lsu_req_valid = 1'b1;
      lsu_addr      = a;
      lsu_wen       = w;
      lsu_wdata     = d;
      lsu_wmask     = m;
      @(negedge clk);
      while (!lsu_req_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!lsu_req_ready) check_eq("lsu_grant_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      lsu_req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && n < 500) begin
         n++;
         @(negedge clk);
      end
      check_eq("drain_timeout", {31'h0, busy}, 32'h0);
      check_eq("scoreboard_empty", exp_q.size(), 32'h0);
      @(posedge clk);
      #1;
   endtask

   function automatic logic any_out();
      return |{ifu_req_ready, ifu_rsp_valid, ifu_rdata, lsu_req_ready, lsu_rsp_valid, lsu_rdata,
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, owner, busy};
   endfunction

   initial begin
      int n;
      int cnt0;
      rst_n = 1'b1;
      ifu_req_valid = 1'b0; ifu_addr = 32'h0;
      lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check_eq("reset_outputs_zero", {31'h0, any_out()}, 32'h0);

      // IFU alone: grant, request, response on consecutive cycles
      @(posedge clk); #1;
      exp_q.push_back(mk(1'b0, 32'h8000_0000));
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0000;
      @(negedge clk);
      check_eq("t1_ready_t0", {31'h0, ifu_req_ready}, 32'h1);
      check_eq("t1_memvalid_t0", {31'h0, mem_req_valid}, 32'h0);
      @(posedge clk); #1;
      ifu_req_valid = 1'b0;
      @(negedge clk);
      check_eq("t1_memvalid_t1", {31'h0, mem_req_valid}, 32'h1);
      check_eq("t1_mem_addr", mem_addr, 32'h8000_0000);
      check_eq("t1_owner", {31'h0, owner}, 32'h0);
      check_eq("t1_mem_wen", {31'h0, mem_wen}, 32'h0);
      @(negedge clk);
      check_eq("t1_rsp_valid_t2", {31'h0, ifu_rsp_valid}, 32'h1);
      check_eq("t1_rdata_t2", ifu_rdata, 32'h0010_0073);
      drain();

      // Simultaneous requests: LSU first, then IFU
      glog.delete();
      exp_q.push_back(mk(1'b1, 32'h8000_3000));
      exp_q.push_back(mk(1'b0, 32'h8000_0004));
      fork
         issue_ifu(32'h8000_0004);
         issue_lsu(32'h8000_3000, 1'b0, 32'h0, 4'h0);
      join
      drain();
      check_eq("t2_grants", glog.size(), 32'd2);
      if (glog.size() == 2) check_eq("t2_order", {30'h0, glog[0], glog[1]}, 32'b10);

      // Starvation: four LSU grants then IFU is forced through
      glog.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b1, 32'h8000_2000 + 32'(4 * i)));
      exp_q.push_back(mk(1'b0, 32'h8000_0100));
      exp_q.push_back(mk(1'b1, 32'h8000_2010));
      fork
         issue_ifu(32'h8000_0100);
         for (int i = 0; i < 5; i++) issue_lsu(32'h8000_2000 + 32'(4 * i), 1'b0, 32'h0, 4'h0);
      join
      drain();
      check_eq("t3_grants", glog.size(), 32'd6);
      if (glog.size() == 6)
         check_eq("t3_order", {26'h0, glog[0], glog[1], glog[2], glog[3], glog[4], glog[5]}, 32'b111101);

      // Counter cleared by the IFU grant: LSU wins again
      glog.delete();
      exp_q.push_back(mk(1'b1, 32'h8000_3004));
      exp_q.push_back(mk(1'b0, 32'h8000_0108));
      fork
         issue_ifu(32'h8000_0108);
         issue_lsu(32'h8000_3004, 1'b0, 32'h0, 4'h0);
      join
      drain();
      if (glog.size() == 2) check_eq("t3_cnt_cleared", {30'h0, glog[0], glog[1]}, 32'b10);
      else check_eq("t3_cnt_grants", glog.size(), 32'd2);

      // Store with memory back-pressure: request held stable across stalls
      stall_cfg = 3;
      cnt0 = lsu_rsp_cnt;
      exp_q.push_back(mk(1'b1, 32'h8000_1000));
      fork
         issue_lsu(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011);
         begin
            n = 0;
            @(negedge clk);
            while (!mem_req_valid && n < 50) begin
               n++;
               @(negedge clk);
            end
            for (int k = 0; k < 4; k++) begin
               check_eq("t4_valid", {31'h0, mem_req_valid}, 32'h1);
               check_eq("t4_addr", mem_addr, 32'h8000_1000);
               check_eq("t4_wdata", mem_wdata, 32'hDEAD_BEEF);
               check_eq("t4_wen_mask", {27'h0, mem_wen, mem_wmask}, 32'b10011);
               check_eq("t4_owner_nogrant", {29'h0, owner, ifu_req_ready, lsu_req_ready}, 32'b100);
               @(negedge clk);
            end
         end
      join
      drain();
      stall_cfg = 0;
      check_eq("t4_rsp_once", lsu_rsp_cnt - cnt0, 32'd1);

      // Reset while in WAIT: transaction dropped, late response ignored
      rsp_delay = 3;
      issue_ifu(32'h8000_0040);
      n = 0;
      @(negedge clk);
      while (!(busy && !mem_req_valid) && n < 50) begin
         n++;
         @(negedge clk);
      end
      check_eq("t5_in_wait", {30'h0, busy, mem_req_valid}, 32'b10);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      check_eq("t5_outputs_zero", {31'h0, any_out()}, 32'h0);
      repeat (3) begin
         @(negedge clk);
         check_eq("t5_no_rsp", {29'h0, busy, ifu_rsp_valid, lsu_rsp_valid}, 32'h0);
      end
      rsp_delay = 0;

      // Stray memory response in IDLE
      spur_cnt++;
      repeat (3) begin
         @(negedge clk);
         check_eq("t6_idle_no_rsp", {29'h0, busy, ifu_rsp_valid, lsu_rsp_valid}, 32'h0);
      end

      check_eq("final_queue_empty", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
